// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr/Count/Compare/Status/Cause/EPC, mfc0/mtc0, exception commit.
// Define CP0_TIMER_EN to build Count/Compare and the timer interrupt; otherwise they read as 0.
module cp0_regs #(
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
    parameter int unsigned COUNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    localparam logic [31:0] StatusWrMask = 32'h0000_FF03;
    localparam logic [31:0] CauseWrMask  = 32'h0000_0300;

    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        exc_hit, eret_hit, mtc0_en;

    assign exc_hit  = excepttype_i inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
    assign eret_hit = (excepttype_i == 32'he);
    // An exception or eret in the same cycle swallows the whole mtc0.
    assign mtc0_en  = we_i && !exc_hit && !eret_hit;

`ifdef CP0_TIMER_EN
    localparam logic [3:0] DivLast = 4'(COUNT_DIV - 1);

    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        timer_q, timer_d;

    always_comb begin
        div_d     = (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
        count_d   = (div_q == DivLast) ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        timer_d   = timer_q || ((count_q == compare_q) && (compare_q != 32'd0));
        if (mtc0_en && waddr_i == 5'd9) begin
            count_d = data_i;
            div_d   = 4'd0;
        end
        if (mtc0_en && waddr_i == 5'd11) begin
            compare_d = data_i;
            timer_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q     <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            timer_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;
`else
    assign count_o     = 32'd0;
    assign compare_o   = 32'd0;
    assign timer_int_o = 1'b0;
`endif

    always_comb begin
        status_d      = status_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        cause_d[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
        if (exc_hit) begin
            if (!status_q[1]) begin
                epc_d      = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]  = 1'b1;
            cause_d[6:2] = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
            if (excepttype_i == 32'h4 || excepttype_i == 32'h5) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (eret_hit) begin
            status_d[1] = 1'b0;
        end else if (mtc0_en) begin
            case (waddr_i)
                5'd12:   status_d = (status_q & ~StatusWrMask) | (data_i & StatusWrMask);
                5'd13:   cause_d[9:8] = data_i[9:8];
                5'd14:   epc_d = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= RESET_STATUS;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign status_o   = status_q;
    // Bit 30 of the stored Cause is never written; TI is merged from the live timer flag.
    assign cause_o    = cause_q | {1'b0, timer_int_o, 30'd0};
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;

    always_comb begin
        case (raddr_i)
            5'd8:    data_o = badvaddr_o;
            5'd9:    data_o = count_o;
            5'd11:   data_o = compare_o;
            5'd12:   data_o = status_o;
            5'd13:   data_o = cause_o;
            5'd14:   data_o = epc_o;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: vector table through a scoreboard, plus timer and reset sequences.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] data_i, excepttype_i, current_inst_addr_i, bad_addr_i;
    logic [5:0]  int_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    int checks = 0;
    int failures = 0;

    cp0_regs dut (
        .clk                 (clk),
        .resetn              (resetn),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .raddr_i             (raddr_i),
        .data_i              (data_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .bad_addr_i          (bad_addr_i),
        .data_o              (data_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .badvaddr_o          (badvaddr_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .timer_int_o         (timer_int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [5:0]  intr;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    string       nm_q[$];

    function automatic vec_t mk(string nm, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] exc, logic [31:0] pc, logic ds, logic [31:0] bad,
                                logic [5:0] intr, logic [4:0] ra, logic [31:0] exp);
        vec_t v;
        v.nm = nm; v.we = we; v.waddr = wa; v.wdata = wd; v.exc = exc; v.pc = pc;
        v.ds = ds; v.bad = bad; v.intr = intr; v.raddr = ra; v.exp = exp;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; excepttype_i = 32'd0;
        current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0; int_i = 6'd0;
    endtask

    initial begin
        logic [31:0] reset_exp [7];
        reset_exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0};

        vecs.push_back(mk("status_mask",   1, 12, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 12, 32'h0040_FF03));
        vecs.push_back(mk("cause_mask",    1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 13, 32'h0000_0300));
        vecs.push_back(mk("badv_ro",       1, 8,  32'h0000_DEAD, 0, 0, 0, 0, 0, 8,  32'h0));
        vecs.push_back(mk("epc_write",     1, 14, 32'h1234_5678, 0, 0, 0, 0, 0, 14, 32'h1234_5678));
        vecs.push_back(mk("status_clr",    1, 12, 32'h0,         0, 0, 0, 0, 0, 12, 32'h0040_0000));
        vecs.push_back(mk("adel_epc",      0, 0, 0, 32'h4, 32'hBFC0_0100, 1, 32'h1234_5671, 0, 14,
                          32'hBFC0_00FC));
        vecs.push_back(mk("adel_cause",    0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h8000_0310));
        vecs.push_back(mk("adel_badv",     0, 0, 0, 0, 0, 0, 0, 0, 8,  32'h1234_5671));
        vecs.push_back(mk("adel_exl",      0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h0040_0002));
        vecs.push_back(mk("sys_epc_held",  0, 0, 0, 32'h8, 32'h0000_0100, 0, 0, 0, 14,
                          32'hBFC0_00FC));
        vecs.push_back(mk("sys_cause",     0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h8000_0320));
        vecs.push_back(mk("eret_exl",      0, 0, 0, 32'he, 0, 0, 0, 0, 12, 32'h0040_0000));
        vecs.push_back(mk("ov_vs_mtc0",    1, 14, 32'h1111_1111, 32'hc, 32'h8000_0000, 0, 0, 0, 14,
                          32'h8000_0000));
        vecs.push_back(mk("ov_cause",      0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h0000_0330));
        vecs.push_back(mk("bad_code",      0, 0, 0, 32'h3, 32'h0000_0500, 0, 0, 0, 12,
                          32'h0040_0002));
        vecs.push_back(mk("eret2",         0, 0, 0, 32'he, 0, 0, 0, 0, 12, 32'h0040_0000));
        vecs.push_back(mk("hw_int_ip",     0, 0, 0, 0, 0, 0, 0, 6'h15, 13, 32'h0000_5730));
        vecs.push_back(mk("hw_int_clr",    0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h0000_0330));
        vecs.push_back(mk("int_exc_epc",   0, 0, 0, 32'h1, 32'h0000_0400, 0, 0, 0, 14,
                          32'h0000_0400));
        vecs.push_back(mk("int_exc_cause", 0, 0, 0, 32'he, 0, 0, 0, 0, 13, 32'h0000_0300));
        vecs.push_back(mk("unmapped",      1, 10, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 10, 32'h0));

        idle_inputs();
        raddr_i = 5'd0;
        resetn = 1'b0;
        repeat (2) tick();
        for (int r = 8; r <= 14; r++) begin
            raddr_i = 5'(r);
            #1;
            chk($sformatf("reset_reg%0d", r), data_o, reset_exp[r - 8]);
        end
        chk("reset_timer", {31'd0, timer_int_o}, 32'd0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata;
            excepttype_i = vecs[i].exc; current_inst_addr_i = vecs[i].pc;
            is_in_delayslot_i = vecs[i].ds; bad_addr_i = vecs[i].bad; int_i = vecs[i].intr;
            raddr_i = vecs[i].raddr;
            exp_q.push_back(vecs[i].exp);
            nm_q.push_back(vecs[i].nm);
            tick();
            chk(nm_q.pop_front(), data_o, exp_q.pop_front());
        end
        idle_inputs();

`ifdef CP0_TIMER_EN
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd5;
        tick();
        waddr_i = 5'd9; data_i = 32'd0;
        tick();
        idle_inputs();
        repeat (9) tick();
        chk("count_at_9", count_o, 32'd4);
        chk("timer_early", {31'd0, timer_int_o}, 32'd0);
        tick();
        chk("count_at_10", count_o, 32'd5);
        tick();
        chk("timer_rise", {31'd0, timer_int_o}, 32'd1);
        chk("cause_ti", {31'd0, cause_o[30]}, 32'd1);
        tick();
        chk("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'h20;
        tick();
        idle_inputs();
        chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
        chk("compare_rd", compare_o, 32'h20);
        // Count write dropped when an exception commits in the same cycle.
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h7777_0000; excepttype_i = 32'h9;
        tick();
        idle_inputs();
        chk("count_drop", {31'd0, count_o == 32'h7777_0000}, 32'd0);
        excepttype_i = 32'he;
        tick();
        idle_inputs();
`else
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h55;
        tick();
        waddr_i = 5'd11; data_i = 32'h1;
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("count_tied", count_o, 32'd0);
        chk("compare_tied", compare_o, 32'd0);
        chk("timer_tied", {31'd0, timer_int_o}, 32'd0);
`endif

        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_epc", epc_o, 32'd0);
        chk("arst_cause", cause_o, 32'd0);
        chk("arst_badv", badvaddr_o, 32'd0);
        chk("arst_count", count_o, 32'd0);
        chk("arst_compare", compare_o, 32'd0);
        chk("arst_timer", {31'd0, timer_int_o}, 32'd0);
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
